// File: rtl/regbank_wb_queue.sv
// Write-back queue feeding the 32x32 register bank's single write port.
// Accepts up to two results per cycle (load unit first, then ALU), drains one
// entry per cycle in arrival order, and forwards still-pending results onto
// both read paths so consumers never observe stale bank data.
module regbank_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_dr,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_dr,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    output logic          write,
    output logic [AW-1:0] dr,
    output logic [DW-1:0] wrData,
    input  logic [AW-1:0] sr1,
    input  logic [AW-1:0] sr2,
    input  logic [DW-1:0] bank_rd1,
    input  logic [DW-1:0] bank_rd2,
    output logic [DW-1:0] rdData1,
    output logic [DW-1:0] rdData2,
    output logic          fwd1,
    output logic          fwd2
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];
    localparam logic [CW:0] ONE_C   = 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [CW:0]   free_slots;
    logic          push_mem;
    logic          push_alu;
    logic          pop;
    logic [PW-1:0] alu_slot;

    logic [AW-1:0] ent_dr   [DEPTH];
    logic [DW-1:0] ent_data [DEPTH];
    logic [PW-1:0] off_idx  [DEPTH];
    logic          off_valid[DEPTH];

    // The head is popped every nonempty cycle, so its slot already counts as free.
    assign pop        = (count_q != '0);
    assign free_slots = DEPTH_C - {1'b0, count_q} + {{CW{1'b0}}, pop};
    assign mem_ready  = (free_slots >= ONE_C);
    // Load unit has priority for the last free slot.
    assign alu_ready  = (free_slots >= (ONE_C + {{CW{1'b0}}, (mem_valid && mem_ready)}));

    assign push_mem = mem_valid && mem_ready;
    assign push_alu = alu_valid && alu_ready;
    // The load is the older instruction, so the ALU entry lands behind it.
    assign alu_slot = tail_q + PW'(push_mem);

    // Next-state for pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push_mem) + PW'(push_alu);
        count_d = count_q + CW'(push_mem) + CW'(push_alu) - CW'(pop);
    end

    // Queue control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [AW-1:0] dr_q;
        logic [DW-1:0] data_q;

        // Capture a load or ALU result when this slot is its push target.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dr_q   <= '0;
                data_q <= '0;
            end else if (push_mem && (tail_q == PW'(gi))) begin
                dr_q   <= mem_dr;
                data_q <= mem_data;
            end else if (push_alu && (alu_slot == PW'(gi))) begin
                dr_q   <= alu_dr;
                data_q <= alu_data;
            end
        end

        assign ent_dr[gi]    = dr_q;
        assign ent_data[gi]  = data_q;
        // Offset gi from the head: physical slot and whether it holds a live entry.
        assign off_idx[gi]   = head_q + PW'(gi);
        assign off_valid[gi] = (CW'(gi) < count_q);
    end

    // Bank write port is driven straight from the head entry (state only).
    assign write  = pop;
    assign dr     = ent_dr[head_q];
    assign wrData = ent_data[head_q];

    // Forwarding: scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        rdData1 = bank_rd1;
        rdData2 = bank_rd2;
        fwd1    = 1'b0;
        fwd2    = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (off_valid[k] && (ent_dr[off_idx[k]] == sr1)) begin
                rdData1 = ent_data[off_idx[k]];
                fwd1    = 1'b1;
            end
            if (off_valid[k] && (ent_dr[off_idx[k]] == sr2)) begin
                rdData2 = ent_data[off_idx[k]];
                fwd2    = 1'b1;
            end
        end
    end

endmodule

// File: doc/regbank_wb_queue.md
# regbank_wb_queue

Write-back queue that acts as the write-side initiator for the 32x32 register bank. It accepts results from two producers, the ALU and the load unit, and can take both in one cycle. It buffers them in order and drains one entry per cycle onto the bank's single write port (`write`/`dr`/`wrData`). It also forwards still-pending results onto the two read paths so consumers never see stale register data.

## Interface
- `DEPTH`, default 4: queue entries; power of two, at least 2.
- `AW`, default 5: register address width.
- `DW`, default 32: data width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_valid`  in  1  load-unit result valid.
- `mem_dr`  in  AW  load-unit destination register.
- `mem_data`  in  DW  load-unit result.
- `mem_ready`  out  1  queue can accept the load-unit result.
- `alu_valid`  in  1  ALU result valid.
- `alu_dr`  in  AW  ALU destination register.
- `alu_data`  in  DW  ALU result.
- `alu_ready`  out  1  queue can accept the ALU result.
- `write`  out  1  bank write enable.
- `dr`  out  AW  bank destination register.
- `wrData`  out  DW  bank write data.
- `sr1`, `sr2`  in  AW  read addresses; also drive the bank's `sr1`/`sr2`.
- `bank_rd1`, `bank_rd2`  in  DW  bank `rdData1`/`rdData2`.
- `rdData1`, `rdData2`  out  DW  forwarded read data.
- `fwd1`, `fwd2`  out  1  the read was satisfied from the queue.

## Operation
- **Storage.** Circular buffer of `{dr, data}` entries with head pointer, tail pointer and count (0..`DEPTH`).
- **Handshake.** A transfer occurs when valid && ready is sampled at the rising edge. Producers hold valid/dr/data until the transfer.
- **Free slots.** `free = DEPTH - count + (count != 0)`. The head entry is popped every nonempty cycle, so its slot counts as free.
- **mem_ready.** Equals `free >= 1`.
- **alu_ready.** Equals `free >= 1 + (mem_valid && mem_ready)`.
  - The load unit has priority for the last slot.
  - `alu_ready` depends combinationally on `mem_valid`.
- **Push order.** When both producers transfer in the same cycle, the mem entry is written at tail and the alu entry at tail+1. The load is the older instruction.
- **Drain.** `write = (count != 0)`. `dr` and `wrData` come directly from the head entry. The head is popped at every edge where `write` = 1. The bank always accepts.
- **Count update.** `count_next = count + pushes - pop`, with pushes in 0..2 and pop in 0..1. Overflow is impossible by construction; the bench asserts `count <= DEPTH`.
- **Pointer wrap.** Pointers wrap modulo `DEPTH`.
- **Forwarding (read port 1; port 2 identical with `sr2`).**
  - Search all valid queue entries, including the head being written this cycle, for `dr == sr1`.
  - If any match, `rdData1` = data of the youngest match and `fwd1` = 1.
  - Otherwise `rdData1` = `bank_rd1` and `fwd1` = 0.
  - Entries being pushed in the current cycle are not forwarded.
- **Register 0.** No special treatment; it is an ordinary register, as in the bank.
- **Duplicate destinations.** Multiple pending entries with the same `dr` are all written, in order. The bank ends with the youngest value.

## Timing
- **Reset.** Asynchronous assertion clears count, pointers and all entry storage. While reset is high:
  - `write` = 0, `dr` = 0, `wrData` = 0, `fwd1` = `fwd2` = 0.
  - `rdData1`/`rdData2` pass through `bank_rd1`/`bank_rd2`.
  - `mem_ready` = 1; `alu_ready` = !`mem_valid` when `DEPTH` = 1, else 1.
- **Reset mid-operation.** Pending entries are discarded and never written.
- **Push-to-write latency.** An entry pushed into an empty queue at edge N drives `write` during cycle N..N+1. The bank updates at edge N+1. The new value appears on `bank_rdX` after edge N+1.
- **Forwarding window.** Forwarding covers the cycle N..N+1, so consumers see the value one cycle after the push edge. The handover from forwarded data to bank data is seamless.
- **Sustained load.** Steady two pushes per cycle fills the queue. The queue then sustains one push per cycle (mem priority). Throughput out is one write per cycle.
- **Combinational paths.** All outputs except `write`/`dr`/`wrData` are combinational from state and inputs. `write`/`dr`/`wrData` depend on state only.

## Test plan
- **Reset.** Assert `reset` mid-cycle with 3 entries queued -> `write` drops immediately, count = 0, no bank writes afterwards, `mem_ready` = `alu_ready` = 1 with `mem_valid` = 0.
- **Single push.** alu push r5 = 0xDEADBEEF into empty queue -> next cycle `write` = 1, `dr` = 5, `wrData` = 0xDEADBEEF. With `sr1` = 5, `rdData1` = 0xDEADBEEF and `fwd1` = 1. After the following edge, `fwd1` = 0 and the bank returns 0xDEADBEEF.
- **Dual push, same destination.** mem r3 = 0x11 and alu r3 = 0x22 in one cycle -> writes r3 = 0x11 then r3 = 0x22 on consecutive cycles. `rdData2` with `sr2` = 3 shows 0x22 while both are pending, and the bank holds 0x22 at the end.
- **Full/backpressure.** Hold both valids with DEPTH = 4 -> count reaches 4, `alu_ready` = 0 while `mem_valid` = 1, `mem_ready` stays 1. Exactly one write per cycle with no loss or reorder; the scoreboard matches 20 mixed pushes.
- **Wrap-around.** Push 10 sequential alu entries r0..r9 with data = 0x100 + index -> bank contents match after drain, pointers wrap twice, count returns to 0 and `write` = 0.
- **Bypass when empty.** Empty queue, `sr1` = 7, `bank_rd1` = 0xCAFE -> `rdData1` = 0xCAFE, `fwd1` = 0.
